// File: rtl/cpu_commit_pkg.sv
// Shared types for the commit stage: the EXECUTE result record, the commit FSM
// state encoding and the default address widths.
package cpu_commit_pkg;

  localparam int DEF_REG_AW = 4;
  localparam int DEF_MEM_AW = 6;

  typedef enum logic {
    RUN     = 1'b0,
    TX_WAIT = 1'b1
  } commit_state_e;

  typedef struct packed {
    logic [31:0]           pc;
    logic                  w_req;
    logic [7:0]            w_data;
    logic                  ack;
    logic                  w_rd;
    logic [31:0]           x_rd;
    logic                  mem_w_req;
    logic [DEF_MEM_AW-1:0] mem_addr;
    logic [31:0]           mem_val;
    logic                  intr_en;
    logic [31:0]           intr_pc;
    logic [31:0]           intr_vec;
  } execute_t;

endpackage

// File: rtl/cpu_commit_if.sv
// EXECUTE -> COMMIT handshake: one result record plus its destination index,
// transferred on ex_valid & ex_ready.
interface cpu_commit_if
  import cpu_commit_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
);
  logic              ex_valid;
  logic              ex_ready;
  execute_t          ex;
  logic [REG_AW-1:0] rd_idx;

  modport master (output ex_valid, output ex, output rd_idx, input ex_ready);
  modport slave  (input ex_valid, input ex, input rd_idx, output ex_ready);
endinterface

// File: rtl/cpu_commit_regfile.sv
// 2-read / 1-write general-purpose register file; x0 always reads zero and
// writes to it are discarded.
module cpu_commit_regfile #(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [31:0]       wd_i,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  output logic [31:0]       rd1_o,
  output logic [31:0]       rd2_o
);

  logic [31:0] regs_q [2**REG_AW];

  // NOTE: storage arrays carry no reset; software must write a register before reading it.
  always_ff @(posedge clk) begin
    if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == '0) ? 32'd0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? 32'd0 : regs_q[ra2_i];

endmodule

// File: rtl/cpu_commit.sv
// Writeback/commit stage: applies each accepted EXECUTE result to the
// architectural state and holds further results while a UART TX byte is pending.
module cpu_commit
  import cpu_commit_pkg::*;
#(
  parameter int          REG_AW   = DEF_REG_AW,
  parameter int          MEM_AW   = DEF_MEM_AW,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  cpu_commit_if.slave       ex_bus,
  input  logic [REG_AW-1:0] rs1_idx,
  input  logic [REG_AW-1:0] rs2_idx,
  output logic [31:0]       x_rs1,
  output logic [31:0]       x_rs2,
  input  logic [MEM_AW-1:0] mem_rd_addr,
  output logic [31:0]       mem_rd_val,
  output logic [31:0]       pc,
  output logic [31:0]       intr_pc,
  output logic [31:0]       intr_vec,
  output logic              intr_en,
  output logic              intr_req,
  output logic              w_busy,
  output logic [7:0]        r_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              irq
);

  commit_state_e state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   intr_pc_q, intr_pc_d;
  logic [31:0]   intr_vec_q, intr_vec_d;
  logic          intr_en_q, intr_en_d;
  logic          intr_pending_q, intr_pending_d;
  logic [7:0]    r_data_q, r_data_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          accept;
  logic [31:0]   mem_q [2**MEM_AW];

  assign ex_bus.ex_ready = (state_q == RUN);
  assign accept          = ex_bus.ex_valid && ex_bus.ex_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    intr_pc_d      = intr_pc_q;
    intr_vec_d     = intr_vec_q;
    intr_en_d      = intr_en_q;
    intr_pending_d = intr_pending_q;
    r_data_d       = r_data_q;
    tx_data_d      = tx_data_q;

    unique case (state_q)
      RUN: begin
        if (accept) begin
          pc_d       = ex_bus.ex.pc;
          intr_en_d  = ex_bus.ex.intr_en;
          intr_pc_d  = ex_bus.ex.intr_pc;
          intr_vec_d = ex_bus.ex.intr_vec;
          if (ex_bus.ex.w_req) begin
            tx_data_d = ex_bus.ex.w_data;
            state_d   = TX_WAIT;
          end
          if (ex_bus.ex.ack) intr_pending_d = 1'b0;
        end
      end
      TX_WAIT: begin
        if (tx_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    // A fresh irq beats an ack committed in the same cycle.
    if (irq)      intr_pending_d = 1'b1;
    if (rx_valid) r_data_d       = rx_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      intr_pc_q      <= '0;
      intr_vec_q     <= '0;
      intr_en_q      <= 1'b0;
      intr_pending_q <= 1'b0;
      r_data_q       <= '0;
      tx_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      intr_pc_q      <= intr_pc_d;
      intr_vec_q     <= intr_vec_d;
      intr_en_q      <= intr_en_d;
      intr_pending_q <= intr_pending_d;
      r_data_q       <= r_data_d;
      tx_data_q      <= tx_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && ex_bus.ex.mem_w_req) begin
      mem_q[ex_bus.ex.mem_addr] <= ex_bus.ex.mem_val;
    end
  end

  cpu_commit_regfile #(
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk   (clk),
    .we_i  (accept && ex_bus.ex.w_rd),
    .wa_i  (ex_bus.rd_idx),
    .wd_i  (ex_bus.ex.x_rd),
    .ra1_i (rs1_idx),
    .ra2_i (rs2_idx),
    .rd1_o (x_rs1),
    .rd2_o (x_rs2)
  );

  assign mem_rd_val = mem_q[mem_rd_addr];
  assign pc         = pc_q;
  assign intr_pc    = intr_pc_q;
  assign intr_vec   = intr_vec_q;
  assign intr_en    = intr_en_q;
  assign intr_req   = intr_pending_q & intr_en_q;
  assign w_busy     = (state_q == TX_WAIT);
  assign tx_valid   = (state_q == TX_WAIT);
  assign tx_data    = tx_data_q;
  assign r_data     = r_data_q;

endmodule

// File: tb/tb_cpu_commit.sv
// Self-checking bench for cpu_commit: a vector table for register/memory/pc
// commits, hand-written TX, interrupt and reset sequences, and a TX scoreboard.
module tb_cpu_commit;
  import cpu_commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rs1_idx, rs2_idx;
  logic [31:0] x_rs1, x_rs2;
  logic [5:0]  mem_rd_addr;
  logic [31:0] mem_rd_val;
  logic [31:0] pc, intr_pc, intr_vec;
  logic        intr_en, intr_req, w_busy;
  logic [7:0]  r_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready, rx_valid, irq;
  logic [7:0]  rx_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  cpu_commit_if u_if ();

  cpu_commit #(
    .REG_AW   (4),
    .MEM_AW   (6),
    .RESET_PC (32'd0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_bus      (u_if.slave),
    .rs1_idx     (rs1_idx),
    .rs2_idx     (rs2_idx),
    .x_rs1       (x_rs1),
    .x_rs2       (x_rs2),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_val  (mem_rd_val),
    .pc          (pc),
    .intr_pc     (intr_pc),
    .intr_vec    (intr_vec),
    .intr_en     (intr_en),
    .intr_req    (intr_req),
    .w_busy      (w_busy),
    .r_data      (r_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .irq         (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input execute_t e, input logic [3:0] rd);
    check("commit_ex_ready", u_if.ex_ready, 1);
    u_if.ex       = e;
    u_if.rd_idx   = rd;
    u_if.ex_valid = 1'b1;
    if (e.w_req) tx_q.push_back(e.w_data);
    step();
    u_if.ex_valid = 1'b0;
    u_if.ex       = '0;
    u_if.rd_idx   = '0;
  endtask

  // TX scoreboard: every handshake must deliver the next expected byte.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_unexpected: got byte %h with no byte expected", tx_data);
      end else begin
        check("tx_byte", tx_data, tx_q.pop_front());
      end
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic        w_rd;
    logic [3:0]  rd;
    logic [31:0] x_rd;
    logic        mem_w;
    logic [5:0]  maddr;
    logic [31:0] mval;
    logic [3:0]  chk1;
    logic [31:0] exp1;
    logic [3:0]  chk2;
    logic [31:0] exp2;
    logic [5:0]  chk_addr;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs[7];

  initial begin
    execute_t    e;
    logic [31:0] last_pc;

    vecs[0] = '{32'd5,  1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 6'd0,  32'h0,        4'd3,  32'hDEADBEEF, 4'd0, 32'h0,        6'd0,  32'hx};
    vecs[1] = '{32'd6,  1'b1, 4'd0,  32'hCAFEF00D, 1'b0, 6'd0,  32'h0,        4'd0,  32'h0,        4'd3, 32'hDEADBEEF, 6'd0,  32'hx};
    vecs[2] = '{32'd7,  1'b0, 4'd0,  32'h0,        1'b1, 6'd0,  32'hA5A5A5A5, 4'd3,  32'hDEADBEEF, 4'd0, 32'h0,        6'd0,  32'hA5A5A5A5};
    vecs[3] = '{32'd8,  1'b0, 4'd0,  32'h0,        1'b1, 6'd63, 32'h12345678, 4'd0,  32'h0,        4'd3, 32'hDEADBEEF, 6'd63, 32'h12345678};
    vecs[4] = '{32'd9,  1'b0, 4'd0,  32'h0,        1'b0, 6'd0,  32'h0,        4'd0,  32'h0,        4'd3, 32'hDEADBEEF, 6'd0,  32'hA5A5A5A5};
    vecs[5] = '{32'd10, 1'b0, 4'd3,  32'hFFFFFFFF, 1'b0, 6'd0,  32'h0,        4'd3,  32'hDEADBEEF, 4'd0, 32'h0,        6'd63, 32'h12345678};
    vecs[6] = '{32'd11, 1'b1, 4'd15, 32'h000000F0, 1'b0, 6'd0,  32'h0,        4'd15, 32'h000000F0, 4'd3, 32'hDEADBEEF, 6'd0,  32'hA5A5A5A5};

    rst = 1'b1;
    u_if.ex_valid = 1'b0;
    u_if.ex = '0;
    u_if.rd_idx = '0;
    rs1_idx = '0;
    rs2_idx = '0;
    mem_rd_addr = '0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data = '0;
    irq = 1'b0;

    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_pc", pc, 32'd0);
    check("rst_intr_en", intr_en, 0);
    check("rst_intr_req", intr_req, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_w_busy", w_busy, 0);
    check("rst_ex_ready", u_if.ex_ready, 1);
    check("rst_r_data", r_data, 0);
    check("rst_x0", x_rs1, 32'd0);

    // Register / memory / pc commit table
    for (int i = 0; i < 7; i++) begin
      e = '0;
      e.pc        = vecs[i].pc;
      e.w_rd      = vecs[i].w_rd;
      e.x_rd      = vecs[i].x_rd;
      e.mem_w_req = vecs[i].mem_w;
      e.mem_addr  = vecs[i].maddr;
      e.mem_val   = vecs[i].mval;
      commit(e, vecs[i].rd);
      rs1_idx     = vecs[i].chk1;
      rs2_idx     = vecs[i].chk2;
      mem_rd_addr = vecs[i].chk_addr;
      #1;
      check($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
      check($sformatf("vec%0d_rs1", i), x_rs1, vecs[i].exp1);
      check($sformatf("vec%0d_rs2", i), x_rs2, vecs[i].exp2);
      if (vecs[i].exp_mem !== 32'hx)
        check($sformatf("vec%0d_mem", i), mem_rd_val, vecs[i].exp_mem);
    end
    last_pc = 32'd11;

    // TX with tx_ready low for 3 cycles; a held ex_valid must be ignored meanwhile
    e = '0;
    e.pc = last_pc;
    e.w_req = 1'b1;
    e.w_data = 8'h41;
    commit(e, 4'd0);
    for (int k = 0; k < 4; k++) begin
      tx_ready = (k == 3);
      u_if.ex_valid = (k < 3);
      u_if.ex = '0;
      u_if.ex.pc = 32'h99;
      #1;
      check($sformatf("txw%0d_tx_valid", k), tx_valid, 1);
      check($sformatf("txw%0d_tx_data", k), tx_data, 8'h41);
      check($sformatf("txw%0d_ex_ready", k), u_if.ex_ready, 0);
      check($sformatf("txw%0d_w_busy", k), w_busy, 1);
      step();
    end
    u_if.ex_valid = 1'b0;
    u_if.ex = '0;
    tx_ready = 1'b0;
    check("txw_done_ex_ready", u_if.ex_ready, 1);
    check("txw_done_w_busy", w_busy, 0);
    check("txw_pc_held", pc, last_pc);

    // TX with tx_ready already high: one-cycle dwell
    tx_ready = 1'b1;
    e = '0;
    e.pc = last_pc;
    e.w_req = 1'b1;
    e.w_data = 8'h42;
    commit(e, 4'd0);
    check("tx1_tx_valid", tx_valid, 1);
    check("tx1_ex_ready", u_if.ex_ready, 0);
    step();
    tx_ready = 1'b0;
    check("tx1_done_ex_ready", u_if.ex_ready, 1);
    check("tx1_done_tx_valid", tx_valid, 0);

    // Interrupts: pending is gated by intr_en; irq beats a same-cycle ack
    irq = 1'b1;
    step();
    irq = 1'b0;
    check("irq_masked", intr_req, 0);
    e = '0;
    e.pc = 32'h20;
    e.intr_en = 1'b1;
    e.intr_pc = 32'h100;
    e.intr_vec = 32'h200;
    commit(e, 4'd0);
    check("irq_req", intr_req, 1);
    check("irq_intr_pc", intr_pc, 32'h100);
    check("irq_intr_vec", intr_vec, 32'h200);
    e.ack = 1'b1;
    irq = 1'b1;
    commit(e, 4'd0);
    irq = 1'b0;
    check("ack_vs_irq", intr_req, 1);
    commit(e, 4'd0);
    check("ack_clears", intr_req, 0);
    check("ack_intr_en", intr_en, 1);

    // Reset in the middle of TX_WAIT discards the pending byte
    e = '0;
    e.pc = 32'h30;
    e.w_req = 1'b1;
    e.w_data = 8'h55;
    commit(e, 4'd0);
    check("rtx_w_busy", w_busy, 1);
    rst = 1'b1;
    void'(tx_q.pop_front());
    step();
    rst = 1'b0;
    check("rtx_tx_valid", tx_valid, 0);
    check("rtx_w_busy_clr", w_busy, 0);
    check("rtx_pc", pc, 32'd0);
    check("rtx_intr_en", intr_en, 0);
    check("rtx_ex_ready", u_if.ex_ready, 1);

    // RX latch: last byte wins
    rx_valid = 1'b1;
    rx_data = 8'h11;
    step();
    rx_data = 8'h7A;
    step();
    rx_valid = 1'b0;
    rx_data = 8'h00;
    step();
    check("rx_r_data", r_data, 8'h7A);

    check("tx_q_empty", tx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
